rr_logb_beat_segmenter: RTL and testbench

- Sequences the root output of the logb merge tree, which is a packed variable-length bus (any_valid/data/len/ready), into fixed-width output beats for the trace-buffer DMA writer.
- Accumulates variable-length records bit-contiguously, LSB-first, and emits full OUT_WIDTH beats.
- On request, flushes the residual partial beat zero-padded, then acknowledges.
- Sits between the logging-bus unpack/pack stage and the PCIM write engine.

---
 rtl/rr_logb_beat_segmenter_pkg.sv | 9 +
 rtl/rr_logb_beat_segmenter_if.sv | 18 +
 rtl/rr_logb_seg_accum.sv | 35 +++
 rtl/rr_logb_beat_segmenter.sv | 60 ++++++
 tb/tb_rr_logb_beat_segmenter.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_logb_beat_segmenter_pkg.sv
// rr_logb_beat_segmenter_pkg: FSM state encoding and fill-counter width helper for the beat segmenter
package rr_logb_beat_segmenter_pkg;
    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    function automatic int fill_width(input int full_w, input int out_w);
        return $clog2(out_w + full_w + 1);
    endfunction
endpackage

// File: rtl/rr_logb_beat_segmenter_if.sv
// rr_logb_beat_segmenter_if: packed input bus plus output beat stream of the beat segmenter
// master drives in_valid/in_data/in_len/out_ready; slave (the segmenter) drives in_ready/out_valid/out_data/out_last
interface rr_logb_beat_segmenter_if #(
    parameter int FULL_WIDTH   = 1024,
    parameter int OUT_WIDTH    = 512,
    parameter int OFFSET_WIDTH = $clog2(FULL_WIDTH + 1)
);
    logic                    in_valid;
    logic [FULL_WIDTH-1:0]   in_data;
    logic [OFFSET_WIDTH-1:0] in_len;
    logic                    in_ready;
    logic                    out_valid;
    logic [OUT_WIDTH-1:0]    out_data;
    logic                    out_last;
    logic                    out_ready;
    modport master (output in_valid, in_data, in_len, out_ready, input in_ready, out_valid, out_data, out_last);
    modport slave (input in_valid, in_data, in_len, out_ready, output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/rr_logb_seg_accum.sv
// rr_logb_seg_accum: bit-contiguous LSB-first accumulation buffer with fill count
// ports: clk, rstn (async active-low); push/len/data append len masked bits; pop drops one OUT_WIDTH beat;
// fill = buffered bit count, beat = low OUT_WIDTH bits of the buffer
module rr_logb_seg_accum #(
    parameter int FULL_WIDTH   = 1024,
    parameter int OUT_WIDTH    = 512,
    parameter int OFFSET_WIDTH = $clog2(FULL_WIDTH + 1),
    parameter int FILL_WIDTH   = $clog2(OUT_WIDTH + FULL_WIDTH + 1)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    push,
    input  logic                    pop,
    input  logic [OFFSET_WIDTH-1:0] len,
    input  logic [FULL_WIDTH-1:0]   data,
    output logic [FILL_WIDTH-1:0]   fill,
    output logic [OUT_WIDTH-1:0]    beat
);
    logic [OUT_WIDTH+FULL_WIDTH-1:0] buffer;
    logic [FULL_WIDTH-1:0]           mask;
    // len==0 shifts the all-ones pattern fully out, giving an empty mask
    assign mask = {FULL_WIDTH{1'b1}} >> (OFFSET_WIDTH'(FULL_WIDTH) - len);
    assign beat = buffer[OUT_WIDTH-1:0];
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            buffer <= '0;
            fill   <= '0;
        end else if (pop) begin
            buffer <= buffer >> OUT_WIDTH;
            fill   <= fill > FILL_WIDTH'(OUT_WIDTH) ? fill - FILL_WIDTH'(OUT_WIDTH) : '0;
        end else if (push) begin
            buffer <= buffer | ({{OUT_WIDTH{1'b0}}, data & mask} << fill);
            fill   <= fill + FILL_WIDTH'(len);
        end
endmodule

// File: rtl/rr_logb_beat_segmenter.sv
// rr_logb_beat_segmenter: packs variable-length logb records into fixed OUT_WIDTH beats, with zero-padded flush
// ports: clk, rstn (async active-low); bus (slave modport: in_valid/in_data/in_len/in_ready, out_valid/out_data/out_last/out_ready);
// flush_req level request, flush_done one-cycle completion pulse, fill_bits buffered bit count
// RR_LOGB_SEG_STATS_EN adds beat_cnt (beats popped) and bit_cnt (accepted bits), cleared on flush_done
module rr_logb_beat_segmenter
    import rr_logb_beat_segmenter_pkg::*;
#(
    parameter int FULL_WIDTH   = 1024,
    parameter int OUT_WIDTH    = 512,
    parameter int OFFSET_WIDTH = $clog2(FULL_WIDTH + 1),
    parameter int FILL_WIDTH   = fill_width(FULL_WIDTH, OUT_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rstn,
    rr_logb_beat_segmenter_if.slave bus,
    input  logic                   flush_req,
    output logic                   flush_done,
    output logic [FILL_WIDTH-1:0]  fill_bits
`ifdef RR_LOGB_SEG_STATS_EN
    ,
    output logic [31:0]            beat_cnt,
    output logic [63:0]            bit_cnt
`endif
);
    logic [1:0] state;
    logic       push, pop, full;
    assign full          = fill_bits >= FILL_WIDTH'(OUT_WIDTH);
    // holding in_ready low while full keeps accept and pop mutually exclusive
    assign bus.in_ready  = rstn && state == ST_ACCUM && !full && !flush_req;
    assign bus.out_valid = full || (state == ST_FLUSH && fill_bits != '0);
    assign bus.out_last  = state == ST_FLUSH && bus.out_valid && fill_bits <= FILL_WIDTH'(OUT_WIDTH);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;
    assign flush_done    = state == ST_DONE;
    rr_logb_seg_accum #(
        .FULL_WIDTH(FULL_WIDTH), .OUT_WIDTH(OUT_WIDTH), .OFFSET_WIDTH(OFFSET_WIDTH), .FILL_WIDTH(FILL_WIDTH)
    ) u_accum (
        .clk(clk), .rstn(rstn), .push(push), .pop(pop), .len(bus.in_len), .data(bus.in_data),
        .fill(fill_bits), .beat(bus.out_data)
    );
    // FLUSH ends when nothing is buffered or the beat carrying out_last is popped
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) state <= ST_ACCUM;
        else state <= state == ST_ACCUM ? (flush_req ? ST_FLUSH : ST_ACCUM)
                    : state == ST_FLUSH ? ((fill_bits == '0 || (pop && bus.out_last)) ? ST_DONE : ST_FLUSH)
                    : ST_ACCUM;
`ifdef RR_LOGB_SEG_STATS_EN
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            beat_cnt <= '0;
            bit_cnt  <= '0;
        end else if (flush_done) begin
            beat_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            beat_cnt <= beat_cnt + 32'(pop);
            bit_cnt  <= bit_cnt + (push ? 64'(bus.in_len) : 64'd0);
        end
`endif
endmodule

// File: tb/tb_rr_logb_beat_segmenter.sv
// tb_rr_logb_beat_segmenter: directed and randomized checks of the beat segmenter against a bit-queue model
module tb_rr_logb_beat_segmenter;
    localparam int FW = 1024;
    localparam int OW = 512;
    localparam int LW = $clog2(FW + 1);
    localparam int CW = $clog2(OW + FW + 1);

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          flush_req;
    logic          flush_done;
    logic [CW-1:0] fill_bits;
`ifdef RR_LOGB_SEG_STATS_EN
    logic [31:0]   beat_cnt;
    logic [63:0]   bit_cnt;
`endif
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rr_logb_beat_segmenter_if #(.FULL_WIDTH(FW), .OUT_WIDTH(OW)) bus ();

    rr_logb_beat_segmenter #(.FULL_WIDTH(FW), .OUT_WIDTH(OW)) dut (
        .clk(clk), .rstn(rstn), .bus(bus), .flush_req(flush_req), .flush_done(flush_done),
        .fill_bits(fill_bits)
`ifdef RR_LOGB_SEG_STATS_EN
        , .beat_cnt(beat_cnt), .bit_cnt(bit_cnt)
`endif
    );

    // model: buffered stream as a queue of bits (index 0 = oldest/LSB), flush phase 0=idle 1=flushing 2=done
    bit          mq[$];
    int          phase = 0;
    logic [31:0] m_beats = '0;
    logic [63:0] m_bits = '0;

    function automatic bit m_ready();
        return rstn && phase == 0 && mq.size() < OW && !flush_req;
    endfunction
    function automatic bit m_valid();
        return mq.size() >= OW || (phase == 1 && mq.size() > 0);
    endfunction
    function automatic bit m_last();
        return phase == 1 && m_valid() && mq.size() <= OW;
    endfunction
    function automatic logic [OW-1:0] m_data();
        logic [OW-1:0] r;
        for (int i = 0; i < OW; i++) r[i] = i < mq.size() ? mq[i] : 1'b0;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    always @(posedge clk or negedge rstn) begin : model
        bit acc, pp;
        int n;
        if (!rstn) begin
            mq.delete();
            phase = 0;
            m_beats = '0;
            m_bits = '0;
        end else begin
            acc = bus.in_valid && m_ready();
            pp = m_valid() && bus.out_ready;
            if (phase == 2) begin
                m_beats = '0;
                m_bits = '0;
            end
            if (pp) begin
                n = mq.size() < OW ? mq.size() : OW;
                repeat (n) void'(mq.pop_front());
                m_beats = m_beats + 32'd1;
            end
            if (acc) begin
                for (int i = 0; i < int'(bus.in_len); i++) mq.push_back(bus.in_data[i]);
                m_bits = m_bits + 64'(bus.in_len);
            end
            if (phase == 0) phase = flush_req ? 1 : 0;
            else if (phase == 1) phase = mq.size() == 0 ? 2 : 1;
            else phase = 0;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", OW'(bus.in_ready), OW'(m_ready()));
        chk("out_valid", OW'(bus.out_valid), OW'(m_valid()));
        chk("fill_bits", OW'(fill_bits), OW'(mq.size()));
        chk("flush_done", OW'(flush_done), OW'(phase == 2));
        if (m_valid()) begin
            chk("out_data", bus.out_data, m_data());
            chk("out_last", OW'(bus.out_last), OW'(m_last()));
        end
`ifdef RR_LOGB_SEG_STATS_EN
        chk("beat_cnt", OW'(beat_cnt), OW'(m_beats));
        chk("bit_cnt", OW'(bit_cnt), OW'(m_bits));
`endif
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drv(input logic v, input logic [FW-1:0] d, input int len, input logic fr, input logic ordy);
        bus.in_valid = v;
        bus.in_data = d;
        bus.in_len = LW'(len);
        flush_req = fr;
        bus.out_ready = ordy;
    endtask

    function automatic logic [FW-1:0] rnd_data();
        logic [FW-1:0] r;
        for (int i = 0; i < FW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        logic [FW-1:0] d1, d2, dd;
        logic [OW-1:0] e;
        int len, fr_hold;
        d1 = '1;
        d2 = {{824{1'b1}}, {200{1'b0}}};
        drv(0, '0, 0, 0, 0);
        repeat (3) step();
        @(negedge clk);
        chk("rst_fill", OW'(fill_bits), '0);
        chk("rst_out_valid", OW'(bus.out_valid), '0);
        chk("rst_in_ready", OW'(bus.in_ready), '0);
        chk("rst_flush_done", OW'(flush_done), '0);
        step();
        rstn = 1'b1;
        // three 200-bit records; middle one has garbage above in_len
        drv(1, d1, 200, 0, 0);
        step();
        drv(1, d2, 200, 0, 0);
        step();
        drv(1, d1, 200, 0, 0);
        step();
        drv(1, d1, 200, 0, 0);
        e = {{112{1'b1}}, {200{1'b0}}, {200{1'b1}}};
        @(negedge clk);
        chk("beat1_valid", OW'(bus.out_valid), OW'(1));
        chk("beat1_data", bus.out_data, e);
        chk("beat1_fill", OW'(fill_bits), OW'(600));
        chk("beat1_in_ready", OW'(bus.in_ready), '0);
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge clk);
            chk("stall_data", bus.out_data, e);
            chk("stall_fill", OW'(fill_bits), OW'(600));
        end
        step();
        drv(0, '0, 0, 0, 1);
        step();
        drv(0, '0, 0, 0, 0);
        @(negedge clk);
        chk("pop_fill", OW'(fill_bits), OW'(88));
        // flush of 88 residual bits; flush_req dropped while flushing
        step();
        drv(0, '0, 0, 1, 1);
        step();
        drv(0, '0, 0, 0, 1);
        @(negedge clk);
        chk("flush_valid", OW'(bus.out_valid), OW'(1));
        chk("flush_data", bus.out_data, {{424{1'b0}}, {88{1'b1}}});
        chk("flush_last", OW'(bus.out_last), OW'(1));
        step();
        @(negedge clk);
        chk("flush_done_pulse", OW'(flush_done), OW'(1));
        chk("flush_fill", OW'(fill_bits), '0);
        step();
        @(negedge clk);
        chk("flush_done_drop", OW'(flush_done), '0);
        // flush with empty buffer, flush_req held across DONE
        step();
        drv(0, '0, 0, 1, 1);
        @(negedge clk);
        chk("empty_done0", OW'(flush_done), '0);
        step();
        @(negedge clk);
        chk("empty_valid", OW'(bus.out_valid), '0);
        chk("empty_done1", OW'(flush_done), '0);
        step();
        @(negedge clk);
        chk("empty_done2", OW'(flush_done), OW'(1));
        step();
        @(negedge clk);
        chk("held_in_ready", OW'(bus.in_ready), '0);
        step();
        drv(0, '0, 0, 0, 1);
        repeat (4) step();
        // zero-length garbage record followed by one byte
        dd = rnd_data();
        drv(1, dd, 0, 0, 1);
        step();
        dd[7:0] = 8'hA5;
        drv(1, dd, 8, 0, 1);
        step();
        drv(0, '0, 0, 0, 1);
        @(negedge clk);
        chk("len8_fill", OW'(fill_bits), OW'(8));
        chk("len8_data", bus.out_data, OW'(8'hA5));
`ifdef RR_LOGB_SEG_STATS_EN
        chk("len8_bit_cnt", OW'(bit_cnt), OW'(8));
`endif
        step();
        drv(0, '0, 0, 1, 1);
        step();
        drv(0, '0, 0, 0, 1);
        repeat (4) step();
        // full-width record splits into two beats
        dd = rnd_data();
        drv(1, dd, FW, 0, 0);
        step();
        drv(0, '0, 0, 0, 0);
        @(negedge clk);
        chk("wide_lo", bus.out_data, dd[OW-1:0]);
        chk("wide_fill", OW'(fill_bits), OW'(FW));
        chk("wide_in_ready", OW'(bus.in_ready), '0);
        step();
        drv(0, '0, 0, 0, 1);
        step();
        @(negedge clk);
        chk("wide_hi", bus.out_data, dd[FW-1:OW]);
        chk("wide_in_ready2", OW'(bus.in_ready), '0);
        step();
        drv(0, '0, 0, 0, 0);
        @(negedge clk);
        chk("wide_empty", OW'(fill_bits), '0);
        chk("wide_in_ready3", OW'(bus.in_ready), OW'(1));
        // randomized traffic with occasional flushes and one reset during a flush
        fr_hold = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            case ($urandom_range(0, 9))
                0: len = 0;
                1: len = FW;
                default: len = $urandom_range(1, FW);
            endcase
            if (cyc == 1500) fr_hold = 4;
            else if (fr_hold > 0) fr_hold--;
            else if ($urandom_range(0, 49) == 0) fr_hold = $urandom_range(1, 6);
            if (cyc == 1502) rstn = 1'b0;
            if (cyc == 1504) rstn = 1'b1;
            drv(1'($urandom_range(0, 1)), rnd_data(), len, fr_hold > 0, $urandom_range(0, 3) != 0);
        end
        step();
        drv(0, '0, 0, 0, 1);
        repeat (10) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
